// File: rtl/clk_div_pkg.sv
// Shared types and default parameter values for the multi-channel integer clock divider.
package clk_div_pkg;

  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_DIV_VALUE_WIDTH = 16;
  localparam int DEF_DONE_DELAY      = 3;

  typedef logic [DEF_DIV_VALUE_WIDTH-1:0] div_val_t;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_RUN   = 2'd1,
    CH_DRAIN = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clk_int_div_ch.sv
// One divider channel: config handshake, period counter, enable FSM, settle counter
// and the bypass gate that passes the source clock straight through when N=1.
module clk_int_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_VALUE_WIDTH = DEF_DIV_VALUE_WIDTH,
  parameter int DONE_DELAY      = DEF_DONE_DELAY,
  parameter bit IDLE_LEVEL      = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       en_i,
  input  logic [DIV_VALUE_WIDTH-1:0] div_i,
  input  logic                       div_valid_i,
  output logic                       div_ready_o,
  output logic                       div_done_o,
  output logic                       tick_o,
  output logic                       clk_o
);

  localparam int DCW = $clog2(DONE_DELAY + 1);
  localparam logic [DCW-1:0] DONE_MAX = DCW'(DONE_DELAY);

  ch_state_e                  state_q, state_d;
  logic [DIV_VALUE_WIDTH-1:0] div_q, div_d;
  logic [DIV_VALUE_WIDTH-1:0] pend_q, pend_d;
  logic                       pend_v_q, pend_v_d;
  logic [DIV_VALUE_WIDTH-1:0] cnt_q, cnt_d;
  logic                       clk_q, clk_d;
  logic                       tick_q, tick_d;
  logic [DCW-1:0]             done_cnt_q, done_cnt_d;
  logic                       byp_gate_q, byp_gate_d;

  logic xfer;
  logic period_end;
  logic apply;

  assign div_ready_o = ~pend_v_q;
  assign xfer        = div_valid_i & ~pend_v_q;
  assign period_end  = (state_q != CH_IDLE) && (cnt_q == div_q);
  // An idle channel is always at a boundary, so a pending value lands immediately.
  assign apply       = pend_v_q && (period_end || (state_q == CH_IDLE));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    done_cnt_d = done_cnt_q;

    if (xfer) begin
      pend_d   = div_i;
      pend_v_d = 1'b1;
    end
    if (apply) begin
      div_d    = pend_q;
      pend_v_d = 1'b0;
    end

    case (state_q)
      CH_IDLE: begin
        cnt_d = '0;
        clk_d = IDLE_LEVEL;
        if (en_i) begin
          state_d = CH_RUN;
          clk_d   = (div_d != '0);
          tick_d  = 1'b1;
        end
      end
      CH_RUN, CH_DRAIN: begin
        if (period_end) begin
          cnt_d = '0;
          if (en_i) begin
            // Bypass keeps the divided path low; the gate carries the clock instead.
            state_d = CH_RUN;
            clk_d   = (div_d != '0);
            tick_d  = 1'b1;
          end else begin
            state_d = CH_IDLE;
            clk_d   = IDLE_LEVEL;
          end
        end else begin
          state_d = en_i ? CH_RUN : CH_DRAIN;
          cnt_d   = cnt_q + DIV_VALUE_WIDTH'(1);
          // Entering cnt = div/2 + 1 = ceil(N/2) ends the high phase.
          if (cnt_q == (div_q >> 1)) begin
            clk_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
        clk_d   = IDLE_LEVEL;
      end
    endcase

    // Periods that end while a new value is pending belong to the old ratio.
    if (!en_i || xfer) begin
      done_cnt_d = '0;
    end else if (period_end && !pend_v_q && (done_cnt_q != DONE_MAX)) begin
      done_cnt_d = done_cnt_q + DCW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= CH_IDLE;
      div_q      <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      cnt_q      <= '0;
      clk_q      <= IDLE_LEVEL;
      tick_q     <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      cnt_q      <= cnt_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Gate enable changes only on the falling edge, while clk_i is low, so the
  // AND-OR clock path cannot glitch when entering or leaving bypass.
  assign byp_gate_d = (state_q != CH_IDLE) && (div_q == '0);

  always_ff @(negedge clk_i) begin
    if (!rst_n_i) begin
      byp_gate_q <= 1'b0;
    end else begin
      byp_gate_q <= byp_gate_d;
    end
  end

  assign clk_o      = clk_q | (byp_gate_q & clk_i);
  assign tick_o     = tick_q;
  assign div_done_o = (done_cnt_q == DONE_MAX);

endmodule

// File: rtl/clk_int_div_multi.sv
// NUM_CH independent runtime-programmable integer clock dividers from one source clock;
// channel k takes its divide value from div_i[k*W +: W].
module clk_int_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int DIV_VALUE_WIDTH = DEF_DIV_VALUE_WIDTH,
  parameter int DONE_DELAY      = DEF_DONE_DELAY,
  parameter bit IDLE_LEVEL      = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_CH-1:0]                 en_i,
  input  logic [NUM_CH*DIV_VALUE_WIDTH-1:0] div_i,
  input  logic [NUM_CH-1:0]                 div_valid_i,
  output logic [NUM_CH-1:0]                 div_ready_o,
  output logic [NUM_CH-1:0]                 div_done_o,
  output logic [NUM_CH-1:0]                 tick_o,
  output logic [NUM_CH-1:0]                 clk_o
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    clk_int_div_ch #(
      .DIV_VALUE_WIDTH (DIV_VALUE_WIDTH),
      .DONE_DELAY      (DONE_DELAY),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .en_i        (en_i[gi]),
      .div_i       (div_i[gi*DIV_VALUE_WIDTH +: DIV_VALUE_WIDTH]),
      .div_valid_i (div_valid_i[gi]),
      .div_ready_o (div_ready_o[gi]),
      .div_done_o  (div_done_o[gi]),
      .tick_o      (tick_o[gi]),
      .clk_o       (clk_o[gi])
    );
  end

endmodule
